// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - conv_ctrl FSM state type and default geometry constants
package conv_pkg;

  localparam int IMG_DEF = 28;
  localparam int AW_DEF  = 10;
  localparam int DW_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } conv_state_t;

endpackage

// File: rtl/conv_delay_line.sv
// rtl/conv_delay_line.sv - DEPTH-stage 1-bit valid pipe with synchronous clear
module conv_delay_line
  import conv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic clr,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] pipe;

  always_ff @(posedge clk) begin
    if (clr) begin
      pipe <= '0;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/conv_ctrl.sv
// rtl/conv_ctrl.sv - 3x3 convolution frame controller; CONV_CTRL_ABORT_EN adds an abort input
module conv_ctrl
  import conv_pkg::*;
#(
  parameter int IMG     = IMG_DEF,
  parameter int AW      = AW_DEF,
  parameter int MUL_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
`ifdef CONV_CTRL_ABORT_EN
  input  logic          abort,
`endif
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          shift_en,
  output logic          win_valid,
  output logic          wr_en,
  output logic [AW-1:0] wr_adr,
  output logic          busy,
  output logic          done
);

  localparam int             CW         = $clog2(IMG);
  localparam logic [CW-1:0]  LAST       = CW'(IMG - 1);
  localparam logic [CW-1:0]  TWO        = CW'(2);
  localparam logic [3:0]     DRAIN_LAST = 4'(MUL_LAT - 1);

  conv_state_t   state, state_nxt;
  logic [CW-1:0] row, col;
  logic [3:0]    drain_cnt;
  logic          last_pix;
  logic          abort_hit;
  logic          frame_go;

`ifdef CONV_CTRL_ABORT_EN
  assign abort_hit = abort & ((state == RUN) | (state == DRAIN));
`else
  assign abort_hit = 1'b0;
`endif

  assign frame_go  = (state == IDLE) & start;
  assign shift_en  = in_valid & in_ready;
  assign win_valid = shift_en & (row >= TWO) & (col >= TWO);
  assign last_pix  = shift_en & (row == LAST) & (col == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (abort_hit) state_nxt = IDLE;
               else if (last_pix) state_nxt = DRAIN;
      DRAIN:   if (abort_hit) state_nxt = IDLE;
               else if (drain_cnt == DRAIN_LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      RUN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      DRAIN:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Counters only move on accepted beats, so in_valid gaps stall the raster position.
  always_ff @(posedge clk) begin
    if (rst) begin
      row       <= '0;
      col       <= '0;
      wr_adr    <= '0;
      drain_cnt <= '0;
    end else begin
      if (frame_go) begin
        row    <= '0;
        col    <= '0;
        wr_adr <= '0;
      end else begin
        if (shift_en) begin
          if (col == LAST) begin
            col <= '0;
            row <= (row == LAST) ? '0 : row + CW'(1);
          end else begin
            col <= col + CW'(1);
          end
        end
        if (wr_en) wr_adr <= wr_adr + AW'(1);
      end
      drain_cnt <= (state == DRAIN) ? drain_cnt + 4'd1 : 4'd0;
    end
  end

  conv_delay_line #(
    .DEPTH(MUL_LAT)
  ) u_delay (
    .clk (clk),
    .clr (rst | abort_hit),
    .din (win_valid),
    .dout(wr_en)
  );

endmodule

// File: tb/tb_conv_ctrl.sv
// tb/tb_conv_ctrl.sv - self-checking bench for conv_ctrl with a timeline model
module tb_conv_ctrl;

  localparam int IMG = 28;
  localparam int LAT = 2;
  localparam int N   = IMG * IMG;

  logic       clk = 1'b0;
  logic       rst, start, in_valid;
  logic       in_ready, shift_en, win_valid, wr_en, busy, done;
  logic [9:0] wr_adr;
`ifdef CONV_CTRL_ABORT_EN
  logic       abort_drv;
`endif

  logic       start5, in_valid5;
  logic       in_ready5, shift_en5, win_valid5, wr_en5, busy5, done5;
  logic [9:0] wr_adr5;

  always #5 clk = ~clk;

  conv_ctrl #(.IMG(IMG), .AW(10), .MUL_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
`ifdef CONV_CTRL_ABORT_EN
    .abort(abort_drv),
`endif
    .start(start), .in_valid(in_valid), .in_ready(in_ready), .shift_en(shift_en),
    .win_valid(win_valid), .wr_en(wr_en), .wr_adr(wr_adr), .busy(busy), .done(done)
  );

  conv_ctrl #(.IMG(5), .AW(10), .MUL_LAT(1)) dut5 (
    .clk(clk), .rst(rst),
`ifdef CONV_CTRL_ABORT_EN
    .abort(1'b0),
`endif
    .start(start5), .in_valid(in_valid5), .in_ready(in_ready5), .shift_en(shift_en5),
    .win_valid(win_valid5), .wr_en(wr_en5), .wr_adr(wr_adr5), .busy(busy5), .done(done5)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model state: a frame is a timeline of beats, scheduled writes and a done cycle.
  int cyc = 0;
  bit in_frame = 0;
  int beats = 0;
  int last_cyc = -1000;
  int wr_cnt = 0;
  int wq[$];

  // Observed statistics of the current frame.
  int beat_idx, first_win, win_cnt, win_sum, wr_seen, adr_bad, last_adr;
  int last_shift, done_cnt, done_dly;
  int wr5, bad5, last_adr5, beats5, last_shift5, done5_cnt, done5_dly;

  always @(negedge clk) begin
    bit er, sh, wv, ew, ed, eb;
    int r, c;
    cyc++;
    if (shift_en) begin
      if (win_valid) begin
        if (first_win < 0) first_win = beat_idx;
        win_cnt++;
        win_sum += beat_idx;
      end
      beat_idx++;
      last_shift = cyc;
    end
    if (wr_en) begin
      if (int'(wr_adr) != wr_seen) adr_bad++;
      wr_seen++;
      last_adr = wr_adr;
    end
    if (done) begin
      done_cnt++;
      done_dly = cyc - last_shift;
    end
    if (shift_en5) begin
      beats5++;
      last_shift5 = cyc;
    end
    if (wr_en5) begin
      if (int'(wr_adr5) != wr5) bad5++;
      wr5++;
      last_adr5 = wr_adr5;
    end
    if (done5) begin
      done5_cnt++;
      done5_dly = cyc - last_shift5;
    end

    if (rst) begin
      in_frame = 0;
      beats    = 0;
      wr_cnt   = 0;
      last_cyc = -1000;
      wq.delete();
    end else begin
      er = in_frame && beats < N;
      sh = er && in_valid;
      r  = beats / IMG;
      c  = beats % IMG;
      wv = sh && r >= 2 && c >= 2;
      ew = wq.size() > 0 && wq[0] == cyc;
      ed = in_frame && beats == N && cyc == last_cyc + LAT + 1;
      eb = in_frame && !ed;
      chk("in_ready", in_ready, er);
      chk("shift_en", shift_en, sh);
      chk("win_valid", win_valid, wv);
      chk("wr_en", wr_en, ew);
      chk("wr_adr", wr_adr, wr_cnt);
      chk("busy", busy, eb);
      chk("done", done, ed);
      if (ew) begin
        void'(wq.pop_front());
        wr_cnt++;
      end
      if (wv) wq.push_back(cyc + LAT);
      if (sh) begin
        beats++;
        if (beats == N) last_cyc = cyc;
      end
      if (ed) in_frame = 0;
      else if (!in_frame && start) begin
        in_frame = 1;
        beats    = 0;
        wr_cnt   = 0;
      end
`ifdef CONV_CTRL_ABORT_EN
      if (abort_drv && eb) begin
        in_frame = 0;
        wq.delete();
      end
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    beat_idx = 0; first_win = -1; win_cnt = 0; win_sum = 0; wr_seen = 0;
    adr_bad = 0; last_adr = -1; last_shift = 0; done_cnt = 0; done_dly = -1;
  endtask

  task automatic check_zero(input string nm);
    chk({nm, ".in_ready"}, in_ready, 0);
    chk({nm, ".shift_en"}, shift_en, 0);
    chk({nm, ".win_valid"}, win_valid, 0);
    chk({nm, ".wr_en"}, wr_en, 0);
    chk({nm, ".busy"}, busy, 0);
    chk({nm, ".done"}, done, 0);
    chk({nm, ".wr_adr"}, wr_adr, 0);
  endtask

  task automatic run_frame(input bit toggle, input int start_at, input int rst_at, input int abort_at);
    clear_stats();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      in_valid = toggle ? (i % 2 == 0) : 1'b1;
      start    = (i == start_at);
      rst      = (i == rst_at);
`ifdef CONV_CTRL_ABORT_EN
      abort_drv = (i == abort_at);
`endif
      tick();
      start = 1'b0;
      rst   = 1'b0;
`ifdef CONV_CTRL_ABORT_EN
      abort_drv = 1'b0;
      if (i == abort_at) begin
        chk("abort.busy_next", busy, 0);
        break;
      end
`endif
      if (i == rst_at) begin
        check_zero("rst_mid");
        break;
      end
      if (done_cnt > 0) break;
    end
    in_valid = 1'b0;
    repeat (6) tick();
  endtask

  task automatic check_full(input string nm);
    chk({nm, ".win_cnt"}, win_cnt, 676);
    chk({nm, ".first_win"}, first_win, 58);
    chk({nm, ".win_sum"}, win_sum, 284258);
    chk({nm, ".wr_cnt"}, wr_seen, 676);
    chk({nm, ".adr_seq_bad"}, adr_bad, 0);
    chk({nm, ".last_adr"}, last_adr, 675);
    chk({nm, ".done_cnt"}, done_cnt, 1);
    chk({nm, ".done_dly"}, done_dly, LAT + 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    start5 = 1'b0; in_valid5 = 1'b0;
`ifdef CONV_CTRL_ABORT_EN
    abort_drv = 1'b0;
`endif
    clear_stats();
    wr5 = 0; bad5 = 0; last_adr5 = -1; beats5 = 0; last_shift5 = 0; done5_cnt = 0; done5_dly = -1;
    repeat (3) tick();
    rst = 1'b0;
    check_zero("reset");

    run_frame(1'b0, -1, -1, -1);
    check_full("plain");

    run_frame(1'b1, -1, -1, -1);
    check_full("gappy");

    run_frame(1'b0, 100, -1, -1);
    check_full("restart_ignored");

    run_frame(1'b0, -1, 400, -1);
    chk("rst_mid.no_done", done_cnt, 0);
    run_frame(1'b0, -1, -1, -1);
    check_full("after_rst");

`ifdef CONV_CTRL_ABORT_EN
    run_frame(1'b0, -1, -1, N);
    chk("abort.done_cnt", done_cnt, 0);
    chk("abort.wr_cnt", wr_seen, 675);
`endif

    start5 = 1'b1;
    tick();
    start5 = 1'b0;
    in_valid5 = 1'b1;
    for (int i = 0; i < 200 && done5_cnt == 0; i++) tick();
    in_valid5 = 1'b0;
    repeat (4) tick();
    chk("img5.beats", beats5, 25);
    chk("img5.wr_cnt", wr5, 9);
    chk("img5.adr_seq_bad", bad5, 0);
    chk("img5.last_adr", last_adr5, 8);
    chk("img5.done_cnt", done5_cnt, 1);
    chk("img5.done_dly", done5_dly, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/conv_ctrl.md
CONV_CTRL -- requirements
Module: conv_ctrl

Interface
REQ-001 Parameter IMG, default 28: input image is IMG x IMG pixels, row-major, one pixel per accepted beat.
REQ-002 Parameter AW, default 10: width of the output address; 2**AW SHALL be at least IMG*IMG.
REQ-003 Parameter MUL_LAT, default 2: cycles from window-valid to result-valid in the 9-multiplier datapath; legal range 1..8.
REQ-004 clk  in  1: single clock; all logic on rising edge.
REQ-005 rst  in  1: synchronous, active-high reset.
REQ-006 start  in  1: one-cycle frame start request.
REQ-007 in_valid  in  1: upstream pixel present on the datapath input this cycle.
REQ-008 in_ready  out  1: controller accepts a pixel this cycle.
REQ-009 shift_en  out  1: advance datapath line buffers; equals in_valid & in_ready.
REQ-010 win_valid  out  1: the pixel shifted this cycle completes a full 3x3 window.
REQ-011 wr_en  out  1: datapath result valid; write result RAM at wr_adr.
REQ-012 wr_adr  out  AW: result RAM address.
REQ-013 busy  out  1: frame in progress (RUN or DRAIN).
REQ-014 done  out  1: one-cycle frame-complete pulse.

Function
REQ-015 The FSM SHALL have states IDLE, RUN, DRAIN and DONE.
REQ-016 IDLE -> RUN on start; clear row, col and wr_adr on this transition.
REQ-017 start outside IDLE SHALL be ignored.
REQ-018 In RUN, in_ready=1; elsewhere in_ready=0.
REQ-019 Each shift_en SHALL advance col; col wraps IMG-1 -> 0 and increments row.
REQ-020 win_valid = shift_en & (row>=2) & (col>=2), using the pre-increment counters.
REQ-021 On the shift of pixel row=IMG-1, col=IMG-1: RUN -> DRAIN.
REQ-022 A MUL_LAT-deep shift register SHALL delay win_valid to produce wr_en.
REQ-023 The shift register SHALL advance every cycle, independent of in_valid gaps.
REQ-024 wr_adr SHALL increment after each wr_en cycle, counting 0 .. (IMG-2)**2-1, which is 675 for IMG=28.
REQ-025 DRAIN SHALL last exactly MUL_LAT cycles, then go to DONE.
REQ-026 DONE SHALL last one cycle with done=1, then go to IDLE.
REQ-027 busy=1 exactly in RUN and DRAIN.
REQ-028 Gaps in in_valid SHALL stall counters only; no window is lost or duplicated.
REQ-029 start together with done (DONE state) SHALL be ignored; a new start is needed in IDLE.

Reset
REQ-030 rst SHALL force state IDLE.
REQ-031 rst SHALL clear row, col, wr_adr and the delay line.
REQ-032 After rst, in_ready, shift_en, win_valid, wr_en, busy and done SHALL all be 0, and wr_adr=0.
REQ-033 rst has priority over start and abort, including in mid-frame, with no done pulse.

Configuration
REQ-034 Macro CONV_CTRL_ABORT_EN, when defined, SHALL add port abort (in, 1).
REQ-035 With the macro defined, abort in RUN or DRAIN SHALL go to IDLE next cycle.
REQ-036 That abort SHALL clear the delay line, so no later wr_en occurs, and SHALL give no done pulse.
REQ-037 With the macro defined, abort in IDLE or DONE has no effect.
REQ-038 Without the macro, the abort port does not exist and frames always run to completion.

Structure
REQ-039 Package conv_pkg SHALL hold the FSM state enum and default constants IMG_DEF=28, AW_DEF=10, DW_DEF=8.
REQ-040 Sub-module conv_delay_line SHALL hold the parameterised MUL_LAT-deep 1-bit valid pipe with synchronous clear.
REQ-041 Row/col counters and the FSM SHALL be inline in conv_ctrl.

Verification
REQ-042 Reset then start, in_valid held 1 for 784 cycles: exactly 676 win_valid pulses; first win_valid on beat 58 (row 2, col 2); exactly 676 wr_en with wr_adr 0..675; done exactly MUL_LAT+1 cycles after the last beat.
REQ-043 Same frame with in_valid toggling 1,0,1,0: still 676 wr_en with identical wr_adr sequence; window positions match the gap-free run.
REQ-044 start pulsed at beat 100 of a running frame: no effect; counts as in REQ-042.
REQ-045 rst asserted at beat 400: next cycle all outputs 0 and IDLE; no done; a fresh start then yields a full 676-write frame.
REQ-046 With CONV_CTRL_ABORT_EN, abort in DRAIN with MUL_LAT=2: no further wr_en; done stays 0; busy=0 next cycle.
REQ-047 IMG=5, MUL_LAT=1: 9 wr_en, wr_adr 0..8; done 2 cycles after the 25th beat.
